mac_feeder: RTL
===============

MAC_FEEDER -- requirements
Module: mac_feeder

Interface
- REQ-001 Parameter DEPTH, default 8: operand-pair buffer depth, power of two.
- REQ-002 Parameter ALU_LAT, default 2: cycles from the ALU sampling valid_in=1 to y including that product.
- REQ-003 clk  input  1: single clock, rising edge.
- REQ-004 R_n  input  1: reset, asynchronous, active-low.
- REQ-005 wr_en  input  1: push {wr_x, wr_b} into the buffer.
- REQ-006 wr_x  input  16: multiplicand to be buffered.
- REQ-007 wr_b  input  16: multiplier to be buffered.
- REQ-008 full  output  1: buffer holds DEPTH pairs.
- REQ-009 empty  output  1: buffer holds 0 pairs.
- REQ-010 start  input  1: single-cycle pulse that begins a job.
- REQ-011 len  input  $clog2(DEPTH)+1: number of pairs in the job, sampled when start is accepted.
- REQ-012 X  output  16: operand to ALU, registered.
- REQ-013 B  output  16: operand to ALU, registered.
- REQ-014 valid_in  output  1: ALU accumulates X*B this cycle, registered.
- REQ-015 alu_clr  output  1: active-high accumulator clear to the ALU (drives R), registered.
- REQ-016 y  input  39: ALU accumulator.
- REQ-017 busy  output  1: job in progress.
- REQ-018 done  output  1: one-cycle pulse; result is valid.
- REQ-019 result  output  39: captured accumulator, held until the next capture.

Function
- REQ-020 The FSM states SHALL be IDLE, CLEAR, STREAM, DRAIN and CAPTURE.
- REQ-021 IDLE: start=1 -> CLEAR, latch len, busy=1 from the next cycle; start is ignored outside IDLE.
- REQ-022 CLEAR: alu_clr=1 for exactly one cycle; len=0 -> DRAIN, else -> STREAM.
- REQ-023 STREAM: each cycle with the buffer non-empty, pop one pair, drive X/B with valid_in=1 the next cycle, and decrement the remaining count.
- REQ-024 STREAM, buffer empty: valid_in=0 bubble; X/B hold their last value; wait with no timeout.
- REQ-025 The last pop SHALL move to DRAIN; DRAIN lasts exactly ALU_LAT cycles after the last valid_in=1 cycle (after alu_clr when len=0).
- REQ-026 CAPTURE: result<=y, done=1 for one cycle, busy=0 -> IDLE.
- REQ-027 Buffer: FIFO order; a write while full is dropped with no state change; a write while empty is poppable the next cycle.
- REQ-028 A simultaneous push and pop when non-empty and not full SHALL leave the count unchanged.
- REQ-029 Pointers SHALL wrap modulo DEPTH; full and empty come from an extra pointer bit.
- REQ-030 A len value greater than DEPTH is legal; the job streams as the buffer is refilled.
- REQ-031 X, B, valid_in and alu_clr SHALL be flop outputs with no combinational path from inputs.

Reset
- REQ-032 R_n=0 SHALL force the following immediately, regardless of clk: state=IDLE; X=0, B=0, valid_in=0, alu_clr=0; busy=0, done=0, result=0; buffer emptied (full=0, empty=1).
- REQ-033 Reset mid-job SHALL abandon the job with no done; the next job starts with CLEAR.

Structure
- REQ-034 Package mac_pkg SHALL hold the operand width (16), accumulator width (39) and the FSM state enum; the ALU shares these widths.
- REQ-035 The buffer SHALL be sub-module mac_feeder_fifo (DEPTH, 32-bit data), and the FSM and counter live in mac_feeder.

Verification
- REQ-036 Push (2,3),(5,4),(1,1),(16,3), then start with len=4 -> alu_clr for 1 cycle, then 4 consecutive valid_in cycles, then done with result=75.
- REQ-037 len=0 -> alu_clr, then ALU_LAT cycles, then done with result=0, and valid_in never asserted.
- REQ-038 Start with len=3 and only (2,3) buffered; push (5,4) and (1,1) 4 cycles later -> valid_in bubbles of 0, then done with result=27.
- REQ-039 Push 9 pairs with DEPTH=8 -> full after 8 pushes; the 9th is dropped; a len=8 job returns the sum of the first 8 products.
- REQ-040 Assert R_n=0 during STREAM -> all outputs at reset values immediately and no done; a following len=1 job with (7,7) -> result=49.
- REQ-041 Pulse start while busy -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths and FSM state encoding for the MAC feeder and its ALU.
package mac_pkg;

    localparam int OP_W  = 16;   // operand width (X, B)
    localparam int ACC_W = 39;   // accumulator width (y, result)

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4
    } state_e;

endpackage

// File: rtl/mac_feeder_fifo.sv
// Operand-pair FIFO: power-of-two depth, pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate count.
module mac_feeder_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_wr;
    logic          do_rd;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Writes while full are dropped; reads while empty are ignored.
    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    end

    // Pointer registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/mac_feeder.sv
// MAC feeder: buffers operand pairs and streams a job of len pairs into a
// pipelined multiply-accumulate ALU, then captures the accumulator.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start; len latched on acceptance
// ST_CLEAR   | alu_clr high for this one cycle
// ST_STREAM  | pop one pair per cycle while buffer non-empty
// ST_DRAIN   | wait ALU_LAT cycles past the last valid_in (or alu_clr)
// ST_CAPTURE | result <= y, done pulses the following cycle
module mac_feeder
    import mac_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 2
) (
    input  logic                    clk,
    input  logic                    R_n,
    input  logic                    wr_en,
    input  logic [OP_W-1:0]         wr_x,
    input  logic [OP_W-1:0]         wr_b,
    output logic                    full,
    output logic                    empty,
    input  logic                    start,
    input  logic [$clog2(DEPTH):0]  len,
    output logic [OP_W-1:0]         X,
    output logic [OP_W-1:0]         B,
    output logic                    valid_in,
    output logic                    alu_clr,
    input  logic [ACC_W-1:0]        y,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        result
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(ALU_LAT + 2);

    state_e             state_q, state_d;
    logic [LW-1:0]      rem_q, rem_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [OP_W-1:0]    x_q, x_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic               vin_q, vin_d;
    logic               clr_q, clr_d;
    logic               done_q, done_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               pop;
    logic [2*OP_W-1:0]  rd_data;

    mac_feeder_fifo #(
        .DEPTH (DEPTH),
        .DW    (2 * OP_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (R_n),
        .wr_en   (wr_en),
        .wr_data ({wr_x, wr_b}),
        .rd_en   (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    assign X        = x_q;
    assign B        = b_q;
    assign valid_in = vin_q;
    assign alu_clr  = clr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign result   = result_q;

    // Job sequencing; the drain down-counter is loaded one higher after a
    // pop because the last valid_in cycle itself is spent in DRAIN.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        drain_d  = drain_q;
        x_d      = x_q;
        b_d      = b_q;
        vin_d    = 1'b0;
        clr_d    = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    rem_d   = len;
                    clr_d   = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (rem_q == '0) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(ALU_LAT - 1);
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!empty) begin
                    pop   = 1'b1;
                    x_d   = rd_data[2*OP_W-1:OP_W];
                    b_d   = rd_data[OP_W-1:0];
                    vin_d = 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LW'(1)) begin
                        state_d = ST_DRAIN;
                        drain_d = DW'(ALU_LAT);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_CAPTURE: begin
                result_d = y;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            drain_q  <= '0;
            x_q      <= '0;
            b_q      <= '0;
            vin_q    <= 1'b0;
            clr_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            drain_q  <= drain_d;
            x_q      <= x_d;
            b_q      <= b_d;
            vin_q    <= vin_d;
            clr_q    <= clr_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

endmodule
